// File: rtl/coherent_dcache.sv
// coherent_dcache: direct-mapped MSI L1 data cache (2-word blocks) with snoop response and halt flush.
// Optional macro DCACHE_HITCOUNT_EN appends a write of the saturating hit counter to HITCNT_ADDR after the flush.
module coherent_dcache #(
  parameter int          CPUID       = 0,
  parameter int          SETS        = 16,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        halt,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - IDXW - 3;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SETS - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  if (((SETS & (SETS - 1)) != 0) || (CPUID < 0) || (CPUID > 1)) begin : g_bad_cfg
    $error("coherent_dcache: SETS must be a power of 2 and CPUID 0 or 1");
  end

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, RD0, RD1, UPGRADE, SNP_WB0, SNP_WB1, FLUSH, FWB0, FWB1,
`ifdef DCACHE_HITCOUNT_EN
    CNT,
`endif
    DONE
  } state_t;

`ifdef DCACHE_HITCOUNT_EN
  localparam state_t SCAN_END = CNT;
`else
  localparam state_t SCAN_END = DONE;
`endif

  state_t state_r, state_s;

  logic [TAGW-1:0] tag_r  [SETS];
  logic [31:0]     data_r [SETS][2];
  logic [SETS-1:0] valid_r, dirty_r;
  logic [31:0]     fill0_r;
  logic [IDXW-1:0] fidx_r;
  logic [28:0]     snp_blk_r;
  logic            snp_inv_r;
  logic            flushed_r;

  logic [TAGW-1:0] req_tag_s, snp_tag_s;
  logic [IDXW-1:0] req_idx_s, snp_idx_s, snp_idx_r;
  logic            req_off_s, req_s, req_hit_s, snp_hit_s, victim_dirty_s, flush_dirty_s;
  logic [31:0]     hitcnt_s;
  logic            unused_s;

  assign req_tag_s      = dmemaddr[31:IDXW+3];
  assign req_idx_s      = dmemaddr[IDXW+2:3];
  assign req_off_s      = dmemaddr[2];
  assign req_s          = dmemREN | dmemWEN;
  assign req_hit_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
  assign victim_dirty_s = valid_r[req_idx_s] && dirty_r[req_idx_s];
  assign snp_tag_s      = ccsnoopaddr[31:IDXW+3];
  assign snp_idx_s      = ccsnoopaddr[IDXW+2:3];
  assign snp_hit_s      = valid_r[snp_idx_s] && (tag_r[snp_idx_s] == snp_tag_s);
  assign snp_idx_r      = snp_blk_r[IDXW-1:0];
  assign flush_dirty_s  = valid_r[fidx_r] && dirty_r[fidx_r];
  assign flushed        = flushed_r;

`ifdef DCACHE_HITCOUNT_EN
  assign unused_s = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};
`else
  assign hitcnt_s = 32'd0;
  assign unused_s = ^{dmemaddr[1:0], ccsnoopaddr[2:0], HITCNT_ADDR, hitcnt_s};
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state and bus/datapath outputs
  always_comb begin
    state_s  = state_r;
    dhit     = 1'b0;
    dmemload = 32'd0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'd0;
    dstore   = 32'd0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    case (state_r)
      IDLE: begin
        // Snoops take precedence; a pending request is simply re-evaluated later.
        if (ccwait) begin
          if (snp_hit_s) begin
            cctrans = 1'b1;
            ccwrite = dirty_r[snp_idx_s];
            state_s = dirty_r[snp_idx_s] ? SNP_WB0 : IDLE;
          end else begin
            state_s = IDLE;
          end
        end else if (halt) begin
          state_s = FLUSH;
        end else if (req_s) begin
          if (req_hit_s) begin
            if (!dmemWEN) begin
              dhit     = 1'b1;
              dmemload = data_r[req_idx_s][req_off_s];
            end else if (dirty_r[req_idx_s]) begin
              dhit = 1'b1;
            end else begin
              state_s = UPGRADE;
            end
          end else begin
            state_s = victim_dirty_s ? WB0 : RD0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WB0, WB1: begin
        dWEN    = 1'b1;
        daddr   = {tag_r[req_idx_s], req_idx_s, (state_r == WB1), 2'b00};
        dstore  = data_r[req_idx_s][state_r == WB1];
        state_s = dwait ? state_r : ((state_r == WB0) ? WB1 : RD0);
      end
      RD0, RD1: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = {dmemaddr[31:3], (state_r == RD1), 2'b00};
        state_s = dwait ? state_r : ((state_r == RD0) ? RD1 : IDLE);
      end
      UPGRADE: begin
        cctrans = 1'b1;
        ccwrite = 1'b1;
        daddr   = {dmemaddr[31:3], 3'b000};
        state_s = dwait ? state_r : IDLE;
      end
      SNP_WB0, SNP_WB1: begin
        dWEN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = 1'b1;
        daddr   = {snp_blk_r, (state_r == SNP_WB1), 2'b00};
        dstore  = data_r[snp_idx_r][state_r == SNP_WB1];
        state_s = dwait ? state_r : ((state_r == SNP_WB0) ? SNP_WB1 : IDLE);
      end
      FLUSH: begin
        if (flush_dirty_s)           state_s = FWB0;
        else if (fidx_r == LAST_IDX) state_s = SCAN_END;
        else                         state_s = FLUSH;
      end
      FWB0, FWB1: begin
        dWEN   = 1'b1;
        daddr  = {tag_r[fidx_r], fidx_r, (state_r == FWB1), 2'b00};
        dstore = data_r[fidx_r][state_r == FWB1];
        if (dwait)                   state_s = state_r;
        else if (state_r == FWB0)    state_s = FWB1;
        else if (fidx_r == LAST_IDX) state_s = SCAN_END;
        else                         state_s = FLUSH;
      end
`ifdef DCACHE_HITCOUNT_EN
      CNT: begin
        dWEN    = 1'b1;
        daddr   = HITCNT_ADDR;
        dstore  = hitcnt_s;
        state_s = dwait ? state_r : DONE;
      end
`endif
      DONE:    state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Line array, fill buffer, snoop latch and flush scan index
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) begin
        tag_r[i]     <= {TAGW{1'b0}};
        data_r[i][0] <= 32'd0;
        data_r[i][1] <= 32'd0;
      end
      valid_r   <= {SETS{1'b0}};
      dirty_r   <= {SETS{1'b0}};
      fill0_r   <= 32'd0;
      fidx_r    <= {IDXW{1'b0}};
      snp_blk_r <= 29'd0;
      snp_inv_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ccwait) begin
            snp_blk_r <= ccsnoopaddr[31:3];
            snp_inv_r <= ccinv;
            if (snp_hit_s && !dirty_r[snp_idx_s] && ccinv) valid_r[snp_idx_s] <= 1'b0;
          end else if (halt) begin
            fidx_r <= {IDXW{1'b0}};
          end else if (req_s && req_hit_s && dmemWEN && dirty_r[req_idx_s]) begin
            data_r[req_idx_s][req_off_s] <= dmemstore;
          end
        end
        RD0: if (!dwait) fill0_r <= dload;
        // The whole block lands in one edge so a reset during the fill leaves the line untouched.
        RD1: if (!dwait) begin
          tag_r[req_idx_s]     <= req_tag_s;
          valid_r[req_idx_s]   <= 1'b1;
          dirty_r[req_idx_s]   <= dmemWEN;
          data_r[req_idx_s][0] <= (dmemWEN && !req_off_s) ? dmemstore : fill0_r;
          data_r[req_idx_s][1] <= (dmemWEN &&  req_off_s) ? dmemstore : dload;
        end
        UPGRADE: if (!dwait) begin
          dirty_r[req_idx_s]           <= 1'b1;
          data_r[req_idx_s][req_off_s] <= dmemstore;
        end
        SNP_WB1: if (!dwait) begin
          dirty_r[snp_idx_r] <= 1'b0;
          valid_r[snp_idx_r] <= ~snp_inv_r;
        end
        FLUSH: if (!flush_dirty_s) fidx_r <= fidx_r + IDX_ONE;
        FWB1: if (!dwait) begin
          valid_r[fidx_r] <= 1'b0;
          dirty_r[fidx_r] <= 1'b0;
          fidx_r          <= fidx_r + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  // Sticky flush-complete flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                flushed_r <= 1'b0;
    else if (state_s == DONE) flushed_r <= 1'b1;
    else                      flushed_r <= flushed_r;
  end

`ifdef DCACHE_HITCOUNT_EN
  logic [31:0] hitcnt_r;
  logic        miss_r;
  assign hitcnt_s = hitcnt_r;

  // Saturating count of requests that completed without going through a miss
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt_r <= 32'd0;
      miss_r   <= 1'b0;
    end else begin
      if ((state_r == IDLE) && ((state_s == WB0) || (state_s == RD0))) miss_r <= 1'b1;
      else if (dhit)                                                  miss_r <= 1'b0;
      if (dhit && !miss_r && (hitcnt_r != 32'hFFFF_FFFF)) hitcnt_r <= hitcnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherent_dcache.sv
// Randomized bench for coherent_dcache: acts as memory controller and checks against a block-level cache/memory model.
module tb_coherent_dcache;
  logic        CLK = 1'b0, nRST;
  logic        dmemREN, dmemWEN, dhit, halt, flushed;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [31:0] daddr, dstore, dload, ccsnoopaddr;

  coherent_dcache #(.CPUID(0), .SETS(16), .HITCNT_ADDR(32'h3100)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit), .halt(halt), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; } beat_t; // kind 0 read, 1 write, 2 upgrade
  beat_t       blog[$];
  beat_t       exp_q[$];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] gmem [logic [31:0]];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [24:0] m_tag [16];
  int          hits_m;
  int          total = 0, bad = 0;
  logic        pend_v;
  logic [31:0] pend_addr, pend_data;
  logic [31:0] a, d;
  int          r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] x);
    return {x[15:0] ^ 16'hC3A5, ~x[15:0]};
  endfunction
  function automatic logic [31:0] rdmem(input logic [31:0] x);
    return bmem.exists(x) ? bmem[x] : init_word(x);
  endfunction
  function automatic logic [31:0] gval(input logic [31:0] x);
    return gmem.exists(x) ? gmem[x] : rdmem(x);
  endfunction

  // Memory side: random acceptance latency; beats are logged when accepted.
  always @(negedge CLK) begin
    if (!nRST) begin
      dwait  = 1'b1;
      pend_v = 1'b0;
    end else if (dREN || dWEN || (cctrans && ccwrite && !ccwait)) begin
      if (pend_v) begin
        check_eq("hold_addr", daddr, pend_addr);
        check_eq("hold_data", dstore, pend_data);
      end
      if ($urandom_range(0, 3) != 0) begin
        dwait  = 1'b0;
        pend_v = 1'b0;
        if (dREN) begin
          dload = rdmem(daddr);
          blog.push_back('{0, daddr, {30'd0, cctrans, ccwrite}});
        end else if (dWEN) begin
          bmem[daddr] = dstore;
          blog.push_back('{1, daddr, dstore});
        end else begin
          blog.push_back('{2, 32'd0, 32'd0});
        end
      end else begin
        dwait     = 1'b1;
        pend_v    = 1'b1;
        pend_addr = daddr;
        pend_data = dstore;
      end
    end else begin
      dwait  = 1'b1;
      pend_v = 1'b0;
    end
  end

  task automatic cmp_log(input string tag, input int start);
    int n;
    n = blog.size() - start;
    check_eq({tag, "_beats"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check_eq({tag, "_kind"}, 32'(blog[start+i].kind), 32'(exp_q[i].kind));
      if (exp_q[i].kind != 2) begin
        check_eq({tag, "_addr"}, blog[start+i].addr, exp_q[i].addr);
        check_eq({tag, "_data"}, blog[start+i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    hits_m = 0;
    gmem.delete();
  endtask

  task automatic do_req(input bit st, input logic [31:0] ad, input logic [31:0] dt);
    logic [3:0]  idx;
    logic [31:0] blk, vb, ld;
    bit          hit, got;
    int          start;
    idx = ad[6:3];
    blk = {ad[31:3], 3'b000};
    hit = m_valid[idx] && (m_tag[idx] == ad[31:7]);
    exp_q.delete();
    if (hit) begin
      hits_m++;
      if (st && !m_dirty[idx]) exp_q.push_back('{2, 32'd0, 32'd0});
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vb = {m_tag[idx], idx, 3'b000};
        exp_q.push_back('{1, vb, gval(vb)});
        exp_q.push_back('{1, vb + 32'd4, gval(vb + 32'd4)});
      end
      exp_q.push_back('{0, blk, {30'd0, 1'b1, st}});
      exp_q.push_back('{0, blk + 32'd4, {30'd0, 1'b1, st}});
    end
    start = blog.size();
    @(posedge CLK); #1;
    dmemaddr = ad; dmemstore = dt; dmemREN = !st; dmemWEN = st;
    got = 1'b0;
    ld  = 32'd0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge CLK); #1;
      if (dhit) begin
        got = 1'b1;
        ld  = dmemload;
      end
    end
    check_eq(st ? "st_done" : "ld_done", 32'(got), 32'd1);
    if (!st) check_eq("ld_data", ld, gval({ad[31:2], 2'b00}));
    cmp_log(st ? "st" : "ld", start);
    if (!hit) m_dirty[idx] = st;
    else if (st) m_dirty[idx] = 1'b1;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = ad[31:7];
    if (st) gmem[{ad[31:2], 2'b00}] = dt;
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic do_snoop(input logic [31:0] ad, input bit inv);
    logic [3:0]  idx;
    logic [31:0] blk;
    bit          hit, dty;
    int          start;
    idx = ad[6:3];
    blk = {ad[31:3], 3'b000};
    hit = m_valid[idx] && (m_tag[idx] == ad[31:7]);
    dty = hit && m_dirty[idx];
    exp_q.delete();
    if (dty) begin
      exp_q.push_back('{1, blk, gval(blk)});
      exp_q.push_back('{1, blk + 32'd4, gval(blk + 32'd4)});
    end
    start = blog.size();
    @(posedge CLK); #1;
    ccwait = 1'b1; ccsnoopaddr = ad; ccinv = inv;
    @(negedge CLK); #1;
    check_eq("snp_cctrans", 32'(cctrans), 32'(hit));
    check_eq("snp_ccwrite", 32'(ccwrite), 32'(dty));
    if (dty) begin
      for (int c = 0; c < 200 && blog.size() < start + 2; c++) begin
        @(negedge CLK); #1;
      end
    end
    @(posedge CLK); #1;
    ccwait = 1'b0; ccinv = 1'b0;
    cmp_log("snp", start);
    if (hit) begin
      m_dirty[idx] = 1'b0;
      if (inv) m_valid[idx] = 1'b0;
    end
  endtask

  task automatic do_flush();
    int start, seen;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        exp_q.push_back('{1, {m_tag[i], 4'(i), 3'b000}, gval({m_tag[i], 4'(i), 3'b000})});
        exp_q.push_back('{1, {m_tag[i], 4'(i), 3'b100}, gval({m_tag[i], 4'(i), 3'b100})});
      end
    end
`ifdef DCACHE_HITCOUNT_EN
    exp_q.push_back('{1, 32'h3100, 32'(hits_m)});
`endif
    start = blog.size();
    @(posedge CLK); #1;
    halt = 1'b1;
    for (int c = 0; c < 600 && !flushed; c++) begin
      @(negedge CLK); #1;
    end
    check_eq("flushed", 32'(flushed), 32'd1);
    cmp_log("flush", start);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    // After DONE: requests and snoops are ignored.
    @(posedge CLK); #1;
    halt = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h40; ccwait = 1'b1; ccsnoopaddr = 32'h40;
    start = blog.size();
    seen  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK); #1;
      if (dhit || cctrans) seen++;
    end
    check_eq("done_quiet", 32'(seen), 32'd0);
    check_eq("done_nobus", 32'(blog.size() - start), 32'd0);
    check_eq("done_sticky", 32'(flushed), 32'd1);
    @(posedge CLK); #1;
    dmemREN = 1'b0; ccwait = 1'b0;
    foreach (gmem[k]) check_eq("mem_coherent", rdmem(k), gmem[k]);
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      a = {23'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'b00};
      d = $urandom;
      r = $urandom_range(0, 9);
      if (r < 4)      do_req(1'b0, a, d);
      else if (r < 8) do_req(1'b1, a, d);
      else            do_snoop(a, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bit found;
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'd0; dmemstore = 32'd0;
    halt = 1'b0; dload = 32'd0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = 32'd0; dwait = 1'b1;
    model_reset();
    #12;
    check_eq("rst_out", {dREN, dWEN, cctrans, ccwrite, dhit, flushed}, 32'd0);
    check_eq("rst_daddr", daddr, 32'd0);
    #10 nRST = 1'b1;

    do_req(1'b0, 32'h40, 32'd0);
    do_req(1'b0, 32'h44, 32'd0);
    do_req(1'b1, 32'h40, 32'hDEAD);
    do_req(1'b0, 32'h40, 32'd0);
    do_req(1'b1, 32'h14, 32'h1234_5678);
    do_req(1'b0, 32'h90, 32'd0);
    do_req(1'b1, 32'h44, 32'hBEEF);
    do_snoop(32'h40, 1'b1);
    do_req(1'b0, 32'h40, 32'd0);
    do_snoop(32'h44, 1'b0);
    rand_ops(160);
    do_req(1'b1, 32'h08, 32'hAAAA_0001);
    do_req(1'b1, 32'h3C, 32'hAAAA_0007);
    do_flush();

    // Reset out of DONE, then reset again in the middle of a fill.
    nRST = 1'b0; #20 nRST = 1'b1;
    model_reset();
    check_eq("rst_flushed", 32'(flushed), 32'd0);
    @(posedge CLK); #1;
    dmemaddr = 32'h200; dmemREN = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge CLK); #1;
      if (dREN && daddr == 32'h204) found = 1'b1;
    end
    check_eq("rd1_reached", 32'(found), 32'd1);
    nRST = 1'b0;
    #1;
    check_eq("midrst_out", {dREN, dWEN, cctrans, ccwrite, dhit, flushed}, 32'd0);
    check_eq("midrst_daddr", daddr, 32'd0);
    dmemREN = 1'b0;
    #13 nRST = 1'b1;
    do_req(1'b0, 32'h200, 32'd0);
    rand_ops(60);
    do_flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
